mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port vector data memory (MEMO_LINES x 64-bit lines) between two requesters:
  - the pipeline MEM stage (requester P);
  - the host loader that preloads plaintext/key data and drains ciphertext (requester H).
- Issues at most one access per cycle and stalls the pipeline when H is granted.
- Routes synchronous-read data back to the owning requester.
- Enforces a bounded-wait anti-starvation rule for H.

Parameters:
ADDR_BITS, 6, memory line address width (64 lines)
DATA_W, 64, memory line width (ELEM_SIZE*VECT_SIZE)
HOST_MAX_WAIT, 4, consecutive denied cycles after which H overrides P; legal range 1..15

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
p_req_i  in  1  pipeline access request, level
p_we_i  in  1  pipeline write (1) / read (0)
p_addr_i  in  ADDR_BITS  pipeline line address
p_wd_i  in  DATA_W  pipeline write data
p_stall_o  out  1  pipeline request pending but not granted this cycle
p_rd_o  out  DATA_W  pipeline read data, held until next P read completes
p_valid_o  out  1  one-cycle pulse: p_rd_o updated
h_req_i  in  1  host access request, level
h_we_i  in  1  host write/read
h_addr_i  in  ADDR_BITS  host line address
h_wd_i  in  DATA_W  host write data
h_gnt_o  out  1  host access accepted this cycle
h_rd_o  out  DATA_W  host read data, held
h_valid_o  out  1  one-cycle pulse: h_rd_o updated
mem_we_o  out  1  memory write enable
mem_a_o  out  ADDR_BITS  memory address
mem_wd_o  out  DATA_W  memory write data
mem_rd_i  in  DATA_W  memory read data, valid cycle after address (synchronous read)

Behaviour:
- Reset (rst_i=0, async): all outputs 0, wait_cnt=0, resp pipeline regs cleared. In-flight read responses are dropped; no valid pulse after reset release.
- Grant decision is combinational, evaluated each cycle:
  - h_win = h_req_i & (~p_req_i | wait_cnt == HOST_MAX_WAIT);
  - p_gnt = p_req_i & ~h_win;
  - h_gnt_o = h_win.
- Memory drive: mem_a_o/mem_we_o/mem_wd_o take the winner's fields. With no winner, mem_we_o=0 and mem_a_o holds its last value.
- p_stall_o = p_req_i & ~p_gnt.
- wait_cnt (4-bit):
  - clears when h_win or ~h_req_i;
  - otherwise increments, saturating at HOST_MAX_WAIT.
- Response tracking uses two register stages.
  - Stage 1 (cycle N+1): captures {owner, is_read} of the cycle-N grant.
  - Stage 2 (end of N+1): if stage-1 is_read, mem_rd_i is registered into the owner's holding register.
  - Owner's valid pulses in cycle N+2.
  - Read latency is therefore 2 cycles from grant.
- Writes produce no valid pulse. A write is committed in its grant cycle.
- Back-to-back reads (one per cycle, any mix of owners) are fully pipelined. Each response goes to its own owner in issue order.
- Same-address read/write in consecutive cycles: memory order only; no forwarding inside the block.
  - A read issued the cycle after a write to the same address returns the new data, provided memory is write-first-then-read across cycles.
- Requesters hold req/addr/we/wd stable until granted. A deasserted request is simply not serviced.
- Arbitration state machine (encoded by wait_cnt):
  - IDLE: no requests.
  - P_OWN: P granted, H may be waiting.
  - H_FORCE: wait_cnt == HOST_MAX_WAIT, next H request wins.
  - H_FORCE → P_OWN after one H grant.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined, adds two outputs:
  - stat_hgnt_o[15:0]: count of H grants;
  - stat_stall_o[15:0]: count of p_stall_o cycles.
- Both counters saturate at 16'hFFFF and clear on reset.
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset check: hold rst_i=0 with random inputs → all outputs 0. Release rst_i, then P read addr 5 issued in cycle N → mem_a_o=5 in N, p_valid_o=1 in N+2, p_rd_o = memory[5].
- Host-only traffic: H write addr 10 data 64'hDEADBEEF_01234567 → h_gnt_o=1 same cycle, mem_we_o=1, no h_valid_o. H read addr 10 next cycle → h_valid_o in +2 with that data.
- Contention, HOST_MAX_WAIT=4: p_req_i and h_req_i both held high from cycle 0.
  - Cycles 0-3: P granted, p_stall_o=0.
  - Cycle 4: h_gnt_o=1, p_stall_o=1.
  - Cycle 5: P again.
  - Pattern repeats every 5 cycles.
- Interleaved reads: P read addr 1 (cycle 0), H read addr 2 (cycle 1), P read addr 3 (cycle 2) → p_valid_o cycles 2 and 4 with mem[1], mem[3]; h_valid_o cycle 3 with mem[2]. p_rd_o holds mem[1] during cycle 3.
- Reset mid-flight: P read granted in cycle N, rst_i=0 in N+1 → p_valid_o never pulses; p_rd_o=0.
- ARB_STATS_EN: 10-cycle contention run with HOST_MAX_WAIT=4 → stat_hgnt_o=2, stat_stall_o=2.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one synchronous-read vector memory between the pipeline (P) and host loader (H).
// Optional grant/stall statistics counters are built when ARB_STATS_EN is defined.
module mem_port_arbiter #(
  parameter int unsigned ADDR_BITS     = 6,
  parameter int unsigned DATA_W        = 64,
  parameter int unsigned HOST_MAX_WAIT = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 p_req_i,
  input  logic                 p_we_i,
  input  logic [ADDR_BITS-1:0] p_addr_i,
  input  logic [DATA_W-1:0]    p_wd_i,
  output logic                 p_stall_o,
  output logic [DATA_W-1:0]    p_rd_o,
  output logic                 p_valid_o,
  input  logic                 h_req_i,
  input  logic                 h_we_i,
  input  logic [ADDR_BITS-1:0] h_addr_i,
  input  logic [DATA_W-1:0]    h_wd_i,
  output logic                 h_gnt_o,
  output logic [DATA_W-1:0]    h_rd_o,
  output logic                 h_valid_o,
  output logic                 mem_we_o,
  output logic [ADDR_BITS-1:0] mem_a_o,
  output logic [DATA_W-1:0]    mem_wd_o,
  input  logic [DATA_W-1:0]    mem_rd_i
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]          stat_hgnt_o,
  output logic [15:0]          stat_stall_o
`endif
);

  localparam logic [3:0] WAIT_MAX = 4'(HOST_MAX_WAIT);

  logic                 h_win;
  logic                 p_gnt;
  logic [3:0]           wait_q, wait_d;
  logic [ADDR_BITS-1:0] last_a_q;
  logic                 s1_rd_q, s1_rd_d;
  logic                 s1_h_q, s1_h_d;
  logic [DATA_W-1:0]    p_rd_q, h_rd_q;
  logic                 p_valid_q, h_valid_q;

  // Grants are gated by reset so every output reads 0 while rst_i is low.
  always_comb begin
    h_win = rst_i & h_req_i & (~p_req_i | (wait_q == WAIT_MAX));
    p_gnt = rst_i & p_req_i & ~h_win;

    p_stall_o = rst_i & p_req_i & ~p_gnt;
    h_gnt_o   = h_win;

    mem_we_o = 1'b0;
    mem_a_o  = last_a_q;
    mem_wd_o = '0;
    if (h_win) begin
      mem_we_o = h_we_i;
      mem_a_o  = h_addr_i;
      mem_wd_o = h_wd_i;
    end else if (p_gnt) begin
      mem_we_o = p_we_i;
      mem_a_o  = p_addr_i;
      mem_wd_o = p_wd_i;
    end

    if (h_win || !h_req_i) begin
      wait_d = '0;
    end else if (wait_q == WAIT_MAX) begin
      wait_d = wait_q;
    end else begin
      wait_d = wait_q + 4'd1;
    end

    s1_rd_d = (h_win & ~h_we_i) | (p_gnt & ~p_we_i);
    s1_h_d  = h_win;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wait_q    <= '0;
      last_a_q  <= '0;
      s1_rd_q   <= 1'b0;
      s1_h_q    <= 1'b0;
      p_rd_q    <= '0;
      h_rd_q    <= '0;
      p_valid_q <= 1'b0;
      h_valid_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      last_a_q  <= mem_a_o;
      s1_rd_q   <= s1_rd_d;
      s1_h_q    <= s1_h_d;
      p_valid_q <= 1'b0;
      h_valid_q <= 1'b0;
      // Stage 2: memory data for last cycle's read lands in its owner's holding register.
      if (s1_rd_q) begin
        if (s1_h_q) begin
          h_rd_q    <= mem_rd_i;
          h_valid_q <= 1'b1;
        end else begin
          p_rd_q    <= mem_rd_i;
          p_valid_q <= 1'b1;
        end
      end
    end
  end

  assign p_rd_o    = p_rd_q;
  assign p_valid_o = p_valid_q;
  assign h_rd_o    = h_rd_q;
  assign h_valid_o = h_valid_q;

`ifdef ARB_STATS_EN
  logic [15:0] stat_hgnt_q, stat_hgnt_d;
  logic [15:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_hgnt_d  = stat_hgnt_q;
    stat_stall_d = stat_stall_q;
    if (h_win && (stat_hgnt_q != '1)) begin
      stat_hgnt_d = stat_hgnt_q + 16'd1;
    end
    if (p_stall_o && (stat_stall_q != '1)) begin
      stat_stall_d = stat_stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stat_hgnt_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_hgnt_q  <= stat_hgnt_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_hgnt_o  = stat_hgnt_q;
  assign stat_stall_o = stat_stall_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a write-first synchronous-read memory model.
// Memory line i starts as 64'hAB00_0000_0000_0000 | i until written.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p_req, p_we, h_req, h_we;
  logic [5:0]  p_addr, h_addr;
  logic [63:0] p_wd, h_wd;
  logic        p_stall, p_valid, h_gnt, h_valid, mem_we;
  logic [63:0] p_rd, h_rd, mem_wd, mem_rd;
  logic [5:0]  mem_a;
`ifdef ARB_STATS_EN
  logic [15:0] stat_hgnt, stat_stall;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] mem_arr [64];
  logic [63:0] wr_mask = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) begin
      mem_arr[mem_a] <= mem_wd;
      wr_mask[mem_a] <= 1'b1;
    end
    mem_rd <= wr_mask[mem_a] ? mem_arr[mem_a] : (64'hAB00_0000_0000_0000 | {58'h0, mem_a});
  end

  mem_port_arbiter #(
    .ADDR_BITS    (6),
    .DATA_W       (64),
    .HOST_MAX_WAIT(4)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .p_req_i  (p_req),
    .p_we_i   (p_we),
    .p_addr_i (p_addr),
    .p_wd_i   (p_wd),
    .p_stall_o(p_stall),
    .p_rd_o   (p_rd),
    .p_valid_o(p_valid),
    .h_req_i  (h_req),
    .h_we_i   (h_we),
    .h_addr_i (h_addr),
    .h_wd_i   (h_wd),
    .h_gnt_o  (h_gnt),
    .h_rd_o   (h_rd),
    .h_valid_o(h_valid),
    .mem_we_o (mem_we),
    .mem_a_o  (mem_a),
    .mem_wd_o (mem_wd),
    .mem_rd_i (mem_rd)
`ifdef ARB_STATS_EN
    ,
    .stat_hgnt_o (stat_hgnt),
    .stat_stall_o(stat_stall)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    p_req = 1'b0; p_we = 1'b0; p_addr = '0; p_wd = '0;
    h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wd = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    // Reset held with random requests: every output stays 0.
    for (int i = 0; i < 3; i++) begin
      p_req  = 1'b1;
      h_req  = 1'b1;
      p_we   = 1'($urandom);
      h_we   = 1'($urandom);
      p_addr = 6'($urandom);
      h_addr = 6'($urandom);
      p_wd   = {$urandom, $urandom};
      h_wd   = {$urandom, $urandom};
      settle();
      check("rst_p_stall", 64'(p_stall), 64'd0);
      check("rst_h_gnt",   64'(h_gnt),   64'd0);
      check("rst_mem_we",  64'(mem_we),  64'd0);
      check("rst_mem_a",   64'(mem_a),   64'd0);
      check("rst_mem_wd",  mem_wd,       64'd0);
      check("rst_p_valid", 64'(p_valid), 64'd0);
      check("rst_h_valid", 64'(h_valid), 64'd0);
      check("rst_p_rd",    p_rd,         64'd0);
      check("rst_h_rd",    h_rd,         64'd0);
`ifdef ARB_STATS_EN
      check("rst_stat_hgnt",  64'(stat_hgnt),  64'd0);
      check("rst_stat_stall", 64'(stat_stall), 64'd0);
`endif
    end
    tick();
    idle_inputs();
    rst_n = 1'b1;

    // P read of line 5: address in cycle N, data pulse in N+2.
    tick();
    p_req = 1'b1; p_addr = 6'd5;
    settle();
    check("p5_mem_a",  64'(mem_a),   64'd5);
    check("p5_mem_we", 64'(mem_we),  64'd0);
    check("p5_stall",  64'(p_stall), 64'd0);
    check("p5_h_gnt",  64'(h_gnt),   64'd0);
    tick();
    p_req = 1'b0;
    settle();
    check("p5_valid_n1", 64'(p_valid), 64'd0);
    check("p5_a_hold",   64'(mem_a),   64'd5);
    tick();
    settle();
    check("p5_valid_n2", 64'(p_valid), 64'd1);
    check("p5_rd",       p_rd,         64'hAB00_0000_0000_0005);
    tick();
    settle();
    check("p5_valid_n3", 64'(p_valid), 64'd0);
    check("p5_rd_hold",  p_rd,         64'hAB00_0000_0000_0005);

    // Host write line 10 then read it back.
    tick();
    h_req = 1'b1; h_we = 1'b1; h_addr = 6'd10; h_wd = 64'hDEADBEEF_01234567;
    settle();
    check("hw_gnt",    64'(h_gnt),  64'd1);
    check("hw_mem_we", 64'(mem_we), 64'd1);
    check("hw_mem_a",  64'(mem_a),  64'd10);
    check("hw_mem_wd", mem_wd,      64'hDEADBEEF_01234567);
    tick();
    h_we = 1'b0; h_wd = '0;
    settle();
    check("hr_gnt",      64'(h_gnt),   64'd1);
    check("hr_mem_we",   64'(mem_we),  64'd0);
    check("hw_no_valid", 64'(h_valid), 64'd0);
    tick();
    h_req = 1'b0;
    settle();
    check("hr_valid_n1", 64'(h_valid), 64'd0);
    tick();
    settle();
    check("hr_valid_n2", 64'(h_valid), 64'd1);
    check("hr_rd",       h_rd,         64'hDEADBEEF_01234567);
    check("hr_p_valid",  64'(p_valid), 64'd0);

    // Interleaved reads P1, H2, P3 in consecutive cycles.
    tick();
    p_req = 1'b1; p_addr = 6'd1;
    settle();
    check("il0_p_valid", 64'(p_valid), 64'd0);
    tick();
    p_req = 1'b0; h_req = 1'b1; h_addr = 6'd2;
    settle();
    check("il1_h_gnt",   64'(h_gnt),   64'd1);
    check("il1_p_valid", 64'(p_valid), 64'd0);
    tick();
    h_req = 1'b0; p_req = 1'b1; p_addr = 6'd3;
    settle();
    check("il2_p_valid", 64'(p_valid), 64'd1);
    check("il2_p_rd",    p_rd,         64'hAB00_0000_0000_0001);
    check("il2_h_valid", 64'(h_valid), 64'd0);
    tick();
    p_req = 1'b0;
    settle();
    check("il3_h_valid", 64'(h_valid), 64'd1);
    check("il3_h_rd",    h_rd,         64'hAB00_0000_0000_0002);
    check("il3_p_valid", 64'(p_valid), 64'd0);
    check("il3_p_rd",    p_rd,         64'hAB00_0000_0000_0001);
    tick();
    settle();
    check("il4_p_valid", 64'(p_valid), 64'd1);
    check("il4_p_rd",    p_rd,         64'hAB00_0000_0000_0003);
    check("il4_h_valid", 64'(h_valid), 64'd0);

    // Reset asserted the cycle after a P read grant drops the response.
    tick();
    p_req = 1'b1; p_addr = 6'd7;
    settle();
    check("mf_p_stall", 64'(p_stall), 64'd0);
    tick();
    p_req = 1'b0;
    rst_n = 1'b0;
    settle();
    check("mf_rst_valid", 64'(p_valid), 64'd0);
    check("mf_rst_rd",    p_rd,         64'd0);
    tick();
    rst_n = 1'b1;
    settle();
    check("mf_rel_valid", 64'(p_valid), 64'd0);
    tick();
    settle();
    check("mf_rel_valid2", 64'(p_valid), 64'd0);
    check("mf_rel_rd",     p_rd,         64'd0);

    // Contention: both requests held, H forced through every fifth cycle.
    tick();
    p_req = 1'b1; p_we = 1'b0; p_addr = 6'd1;
    h_req = 1'b1; h_we = 1'b0; h_addr = 6'd2;
    for (int c = 0; c < 10; c++) begin
      settle();
      check($sformatf("ct%0d_h_gnt", c),   64'(h_gnt),   64'((c % 5) == 4));
      check($sformatf("ct%0d_p_stall", c), 64'(p_stall), 64'((c % 5) == 4));
      check($sformatf("ct%0d_mem_a", c),   64'(mem_a),   ((c % 5) == 4) ? 64'd2 : 64'd1);
      tick();
    end
    idle_inputs();
`ifdef ARB_STATS_EN
    settle();
    check("stat_hgnt",  64'(stat_hgnt),  64'd2);
    check("stat_stall", 64'(stat_stall), 64'd2);
`endif
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
